// File: rtl/mcdt_fmt_pkg.sv
// Shared types for the mcdt packet formatter: FSM states, FIFO entry layout, word builders.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mcdt_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2,
        TAIL    = 2'd3
    } fmt_state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] TRL_MAGIC = 8'h5A;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } fifo_entry_t;

    function automatic logic [31:0] mk_header(input logic [1:0] id, input logic [15:0] seq);
        return {HDR_MAGIC, 6'b0, id, seq};
    endfunction

    function automatic logic [31:0] mk_trailer(input logic [1:0] id, input logic [7:0] cnt);
        return {TRL_MAGIC, 6'b0, id, 8'h00, cnt};
    endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Synchronous first-word-fall-through FIFO of {id,data} entries with occupancy count.
// Latency: a word written at edge N is visible at the head after edge N.
// Backpressure: writes while full are ignored; reads while empty are ignored.
module mcdt_fmt_fifo
    import mcdt_fmt_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_vld,
    input  fifo_entry_t               i_wr_dat,
    input  logic                      i_rd_rdy,
    output fifo_entry_t               o_rd_dat,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_count  = r_count;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_wr     = i_wr_vld && !o_full;
    assign w_rd     = i_rd_rdy && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mcdt_pkt_formatter.sv
// Buffers arbiter words and frames same-channel runs as header/payload/trailer packets.
// Latency: word sampled at edge N into an idle empty block -> header valid after edge N+2.
// Backpressure: valid/ready out; none towards the arbiter, words arriving while full are dropped.
module mcdt_pkt_formatter
    import mcdt_fmt_pkg::*;
#(
    parameter int FIFO_DEPTH   = 32,
    parameter int PKT_LEN      = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [31:0]                   mcdt_data_i,
    input  logic                          mcdt_val_i,
    input  logic [1:0]                    mcdt_id_i,
    output logic [31:0]                   fmt_data_o,
    output logic                          fmt_valid_o,
    input  logic                          fmt_ready_i,
    output logic                          fmt_sop_o,
    output logic                          fmt_eop_o,
    output logic [$clog2(FIFO_DEPTH):0]   fmt_margin_o,
    output logic                          fmt_overflow_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    fmt_state_t    r_state;
    fmt_state_t    w_state_nxt;
    fifo_entry_t   w_wr_dat;
    fifo_entry_t   w_head;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic          w_pop;

    logic [1:0]    r_pkt_id;
    logic [7:0]    r_count;
    logic [15:0]   r_seq;
    logic [TW-1:0] r_to;
    logic          r_overflow;
    logic [CW-1:0] r_margin;

    logic          r_fmt_valid;
    logic [31:0]   r_fmt_data;
    logic          r_fmt_sop;
    logic          r_fmt_eop;

    logic          w_capture;
    logic          w_seq_inc;
    logic          w_load;
    logic [31:0]   w_load_dat;
    logic          w_load_sop;
    logic          w_load_eop;
    logic          w_out_free;
    logic          w_head_match;
    logic          w_to_hit;

    assign w_wr_dat = '{id: mcdt_id_i, data: mcdt_data_i};

    mcdt_fmt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (clk_i),
        .i_rst_n  (rstn_i),
        .i_wr_vld (mcdt_val_i),
        .i_wr_dat (w_wr_dat),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_head),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .o_count  (w_count)
    );

    assign w_out_free   = !r_fmt_valid || fmt_ready_i;
    assign w_head_match = !w_empty && (w_head.id == r_pkt_id);
    assign w_to_hit     = (r_to >= TW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // The output register acts as the pipeline slot: a new word is loaded
    // whenever the current one leaves (or none is held), so payloads stream.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pop       = 1'b0;
        w_seq_inc   = 1'b0;
        w_load      = 1'b0;
        w_load_dat  = '0;
        w_load_sop  = 1'b0;
        w_load_eop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HEAD;
                end
            end
            HEAD: begin
                if (!r_fmt_valid) begin
                    w_load     = 1'b1;
                    w_load_dat = mk_header(r_pkt_id, r_seq);
                    w_load_sop = 1'b1;
                end else if (fmt_ready_i) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_out_free) begin
                    if (r_count == 8'(PKT_LEN)) begin
                        w_load      = 1'b1;
                        w_load_dat  = mk_trailer(r_pkt_id, r_count);
                        w_load_eop  = 1'b1;
                        w_state_nxt = TAIL;
                    end else if (w_head_match) begin
                        w_load     = 1'b1;
                        w_load_dat = w_head.data;
                        w_pop      = 1'b1;
                    end else if (!w_empty || w_to_hit) begin
                        w_load      = 1'b1;
                        w_load_dat  = mk_trailer(r_pkt_id, r_count);
                        w_load_eop  = 1'b1;
                        w_state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (r_fmt_valid && fmt_ready_i) begin
                    w_seq_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pkt_id   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_to       <= '0;
            r_overflow <= 1'b0;
            r_margin   <= CW'(FIFO_DEPTH);
        end else begin
            if (w_capture) begin
                r_pkt_id <= w_head.id;
                r_count  <= '0;
            end else if (w_pop) begin
                r_count  <= r_count + 1'b1;
            end
            if (w_seq_inc) r_seq <= r_seq + 1'b1;
            // Only a run of empty cycles inside PAYLOAD may close a packet.
            if (r_state != PAYLOAD || !w_empty) r_to <= '0;
            else if (!w_to_hit)                 r_to <= r_to + 1'b1;
            if (mcdt_val_i && w_full) r_overflow <= 1'b1;
            r_margin <= CW'(FIFO_DEPTH) - w_count;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fmt_valid <= 1'b0;
            r_fmt_data  <= '0;
            r_fmt_sop   <= 1'b0;
            r_fmt_eop   <= 1'b0;
        end else if (w_load) begin
            r_fmt_valid <= 1'b1;
            r_fmt_data  <= w_load_dat;
            r_fmt_sop   <= w_load_sop;
            r_fmt_eop   <= w_load_eop;
        end else if (r_fmt_valid && fmt_ready_i) begin
            r_fmt_valid <= 1'b0;
            r_fmt_sop   <= 1'b0;
            r_fmt_eop   <= 1'b0;
        end
    end

    assign fmt_valid_o    = r_fmt_valid;
    assign fmt_data_o     = r_fmt_data;
    assign fmt_sop_o      = r_fmt_sop;
    assign fmt_eop_o      = r_fmt_eop;
    assign fmt_margin_o   = r_margin;
    assign fmt_overflow_o = r_overflow;

endmodule
